mul_share_arb: RTL and testbench

Round-robin arbiter and sequencer sharing one fixed-latency pipelined multiplier (plain registered pipeline, no valid/stall) between NUM_REQ requesters. Issues at most one operand pair per cycle and tracks each operation's requester ID through the multiplier latency. Captures products into a credit-protected result FIFO so downstream backpressure never loses a result. Sits between requesting datapath blocks and a standard-cell multiplier macro.

---
 rtl/mul_share_arb.sv | 170 +++++++++++++++++
 tb/tb_mul_share_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// Shares one fixed-latency pipelined multiplier among NUM_REQ requesters, tracking IDs
// through the pipe into a credit-protected result FIFO. Define MUL_SHARE_RR_EN for round-robin.
module mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [2*WIDTH-1:0]         mul_o,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [2*WIDTH-1:0]         resp_data
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int DEPTH = LATENCY + 3;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TV_W  = LATENCY + 1;
    localparam int TAG_W = TV_W * ID_W;

    logic               gnt_any;
    logic [ID_W-1:0]    gnt_idx;
    logic               can_issue;
    logic               issue;
    logic               push;
    logic               pop;

    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [TV_W-1:0]    tag_v_q, tag_v_d;
    logic [TAG_W-1:0]   tag_id_q, tag_id_d;
    logic [ID_W-1:0]    fid_q  [DEPTH];
    logic [ID_W-1:0]    fid_d  [DEPTH];
    logic [2*WIDTH-1:0] fdat_q [DEPTH];
    logic [2*WIDTH-1:0] fdat_d [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   outst_q, outst_d;

`ifdef MUL_SHARE_RR_EN
    logic [ID_W-1:0]    ptr_q, ptr_d;
    int unsigned        rr_idx;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_idx  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_idx = (32'(ptr_q) + k) % 32'(NUM_REQ);
            if (!gnt_any && req_valid[ID_W'(rr_idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(rr_idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!gnt_any && req_valid[ID_W'(k)]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(k);
            end
        end
    end
`endif

    // outstanding = FIFO occupancy + in-flight tags; issue only while a slot is guaranteed
    assign can_issue = (outst_q < CNT_W'(DEPTH));
    assign issue     = gnt_any & can_issue & rst_n;
    assign push      = tag_v_q[LATENCY];
    assign pop       = resp_valid & resp_ready;

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        if (issue) begin
            mul_a_d = req_a[32'(gnt_idx)*WIDTH +: WIDTH];
            mul_b_d = req_b[32'(gnt_idx)*WIDTH +: WIDTH];
        end
        tag_v_d  = (tag_v_q << 1) | TV_W'(issue);
        tag_id_d = (tag_id_q << ID_W) | TAG_W'(gnt_idx);
    end

    always_comb begin
        fid_d  = fid_q;
        fdat_d = fdat_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (push) begin
            fid_d[wr_q]  = tag_id_q[LATENCY*ID_W +: ID_W];
            fdat_d[wr_q] = mul_o;
            wr_d         = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        case ({issue, pop})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
            fid_q    <= '{default: '0};
            fdat_q   <= '{default: '0};
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            outst_q  <= '0;
        end else begin
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            fid_q    <= fid_d;
            fdat_q   <= fdat_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            outst_q  <= outst_d;
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign resp_valid = (cnt_q != '0);
    assign resp_id    = resp_valid ? fid_q[rd_q]  : '0;
    assign resp_data  = resp_valid ? fdat_q[rd_q] : '0;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: LATENCY=3 instance with a scoreboard on results,
// plus a LATENCY=0 instance for the minimum-latency corner.
module tb_mul_share_arb;
    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   rv3, rr3, rv0, rr0;
    logic [127:0] ra3, rb3, ra0, rb0;
    logic [31:0]  ma3, mb3, ma0, mb0;
    logic [63:0]  mo3, mo0, p1, p2, p3;
    logic         resp_v3, resp_rdy3, resp_v0, resp_rdy0;
    logic [1:0]   resp_id3, resp_id0;
    logic [63:0]  resp_d3, resp_d0;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_unexp  = 0;
    logic [65:0]  sb_q [$];
    logic [65:0]  sb_head;
    int           cnt [4];
    bit           rnd = 1'b0;

    always #5 clk = ~clk;

    // LATENCY=3 multiplier model: three plain registers
    always @(posedge clk) begin
        p1 <= {32'd0, ma3} * {32'd0, mb3};
        p2 <= p1;
        p3 <= p2;
    end
    assign mo3 = p3;
    assign mo0 = {32'd0, ma0} * {32'd0, mb0};

    mul_share_arb #(.NUM_REQ(4), .WIDTH(32), .LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(rr3),
        .req_a(ra3), .req_b(rb3), .mul_a(ma3), .mul_b(mb3), .mul_o(mo3),
        .resp_valid(resp_v3), .resp_ready(resp_rdy3), .resp_id(resp_id3), .resp_data(resp_d3)
    );

    mul_share_arb #(.NUM_REQ(4), .WIDTH(32), .LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0),
        .req_a(ra0), .req_b(rb0), .mul_a(ma0), .mul_b(mb0), .mul_o(mo0),
        .resp_valid(resp_v0), .resp_ready(resp_rdy0), .resp_id(resp_id0), .resp_data(resp_d0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: report which requesters were accepted, then present their next operands.
    task automatic step(output logic [3:0] acc);
        @(negedge clk);
        acc = rv3 & rr3;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                cnt[i]++;
                ra3[i*32 +: 32] = rnd ? $urandom : 32'(i*1000 + cnt[i]);
                rb3[i*32 +: 32] = rnd ? $urandom : 32'(cnt[i] + 5);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rv3[i] && rr3[i])
                    sb_q.push_back({2'(i), {32'd0, ra3[i*32 +: 32]} * {32'd0, rb3[i*32 +: 32]}});
            end
            if (resp_v3 && resp_rdy3) begin
                if (sb_q.size() == 0) begin
                    n_unexp++;
                end else begin
                    sb_head = sb_q.pop_front();
                    chk("resp_id", 64'(resp_id3), 64'(sb_head[65:64]));
                    chk("resp_data", resp_d3, sb_head[63:0]);
                end
            end
        end
    end

    initial begin
        logic [3:0] acc;
        int         na;
        int         ns;
        rv3 = '0; rv0 = '0; ra3 = '0; rb3 = '0; ra0 = '0; rb0 = '0;
        resp_rdy3 = 1'b0; resp_rdy0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            ra3[i*32 +: 32] = 32'(i*1000);
            rb3[i*32 +: 32] = 32'd5;
        end

        // reset with requests pending: nothing may be granted
        #1 rst_n = 1'b0;
        rv3 = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(rr3), 64'd0);
        chk("rst_mul_a", 64'(ma3), 64'd0);
        chk("rst_mul_b", 64'(mb3), 64'd0);
        chk("rst_resp_valid", 64'(resp_v3), 64'd0);
        chk("rst_resp_id", 64'(resp_id3), 64'd0);
        chk("rst_resp_data", resp_d3, 64'd0);

        // release; cycle 0: requester 2 sends 7*6, LATENCY=0 instance sends max*max
        @(posedge clk); #1;
        rst_n = 1'b1;
        rv3 = 4'b0100;
        ra3[64 +: 32] = 32'd7;
        rb3[64 +: 32] = 32'd6;
        rv0 = 4'b0001;
        ra0[31:0] = 32'hFFFF_FFFF;
        rb0[31:0] = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("single_ready", 64'(rr3), 64'h4);
        chk("l0_ready", 64'(rr0), 64'h1);
        @(posedge clk); #1;
        rv3 = '0; rv0 = '0;
        @(negedge clk);
        chk("single_mul_a", 64'(ma3), 64'd7);
        chk("single_mul_b", 64'(mb3), 64'd6);
        chk("l0_resp_early", 64'(resp_v0), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l0_resp_valid", 64'(resp_v0), 64'd1);
        chk("l0_resp_data", resp_d0, 64'hFFFF_FFFE_0000_0001);
        chk("l0_resp_id", 64'(resp_id0), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("single_early", 64'(resp_v3), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("single_valid", 64'(resp_v3), 64'd1);
        chk("single_id", 64'(resp_id3), 64'd2);
        chk("single_data", resp_d3, 64'd42);
        @(posedge clk); #1;
        resp_rdy3 = 1'b1;
        @(negedge clk);
        chk("single_hold", resp_d3, 64'd42);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_popped", 64'(resp_v3), 64'd0);

        // all requesters valid continuously
        @(posedge clk); #1;
        rv3 = 4'hF;
        for (int k = 0; k < 8; k++) begin
            step(acc);
`ifdef MUL_SHARE_RR_EN
            // the grant to requester 2 above left the pointer at 3
            chk("arb_grant", 64'(acc), 64'(4'b0001 << ((3 + k) % 4)));
`else
            chk("arb_grant", 64'(acc), 64'h1);
`endif
        end

        // backpressure: credit allows exactly LATENCY+3 outstanding
        rv3 = '0;
        repeat (10) step(acc);
        resp_rdy3 = 1'b0;
        rv3 = 4'hF;
        na = 0;
        repeat (15) begin
            step(acc);
            na += $countones(acc);
        end
        chk("bp_accepts", 64'(na), 64'd6);
        @(negedge clk);
        chk("bp_stalled", 64'(rr3), 64'd0);
        @(posedge clk); #1;
        resp_rdy3 = 1'b1;
        @(posedge clk); #1;
        resp_rdy3 = 1'b0;
        step(acc);
        chk("bp_resume_next", 64'($countones(acc)), 64'd1);
        na = $countones(acc);
        repeat (9) begin
            step(acc);
            na += $countones(acc);
        end
        chk("bp_resume_total", 64'(na), 64'd1);

        // drain, then 1000 random operations at full rate
        rv3 = '0;
        resp_rdy3 = 1'b1;
        repeat (12) step(acc);
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        rnd = 1'b1;
        rv3 = 4'hF;
        na = 0;
        repeat (1000) begin
            step(acc);
            na += $countones(acc);
        end
        chk("tp_issues", 64'(na), 64'd1000);
        rv3 = '0;
        repeat (12) step(acc);
        chk("tp_drain_empty", 64'(sb_q.size()), 64'd0);

        // reset mid-stream with results pending
        rv3 = 4'hF;
        repeat (6) step(acc);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req_ready", 64'(rr3), 64'd0);
        chk("rst_mid_mul_a", 64'(ma3), 64'd0);
        chk("rst_mid_mul_b", 64'(mb3), 64'd0);
        chk("rst_mid_resp_valid", 64'(resp_v3), 64'd0);
        chk("rst_mid_resp_id", 64'(resp_id3), 64'd0);
        chk("rst_mid_resp_data", resp_d3, 64'd0);
        rv3 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ns = 0;
        repeat (15) begin
            @(negedge clk);
            ns += int'(resp_v3);
        end
        chk("no_stale", 64'(ns), 64'd0);
        chk("unexpected_resp", 64'(n_unexp), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
